// File: rtl/relu_stage.sv
// relu_stage: registered per-lane ReLU with an output-valid qualifier
module relu_stage #(
  parameter int WIDTH = 8,
  parameter int LANES = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH*LANES-1:0]   in,
  input  logic                     en,
  output logic [WIDTH*LANES-1:0]   out,
  output logic                     out_en
);
  logic [WIDTH*LANES-1:0] relu;
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign relu[k*WIDTH +: WIDTH] = in[k*WIDTH+WIDTH-1] ? '0 : in[k*WIDTH +: WIDTH];
  end
  // register the clamped vector when enabled, otherwise park both outputs at zero
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      out    <= '0;
      out_en <= 1'b0;
    end else begin
      out    <= en ? relu : '0;
      out_en <= en;
    end
endmodule

// File: tb/tb_relu_stage.sv
// tb_relu_stage: scoreboard bench for a four-lane relu_stage
module tb_relu_stage;
  localparam int W = 8;
  localparam int L = 4;
  localparam int N = W*L;
  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] in;
  logic         en;
  logic [N-1:0] out;
  logic         out_en;
  int           errors = 0;
  int           checks = 0;
  logic [N-1:0] exp_q[$];

  relu_stage #(.WIDTH(W), .LANES(L)) dut (
    .clk(clk), .reset(reset), .in(in), .en(en), .out(out), .out_en(out_en)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] relu_ref(input logic [N-1:0] v);
    logic [N-1:0] r;
    for (int k = 0; k < L; k++) begin
      int x;
      x = int'($signed(v[k*W +: W]));
      r[k*W +: W] = (x < 0) ? W'(0) : W'(x);
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [N:0] act, input logic [N:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive(input logic e, input logic [N-1:0] d);
    @(negedge clk);
    en = e;
    in = d;
  endtask

  // reference model: every accepted vector yields one expected result; reset discards pending ones
  always @(posedge clk or negedge reset)
    if (!reset) exp_q.delete();
    else if (en === 1'b1) exp_q.push_back(relu_ref(in));

  // monitor: compare whatever the DUT presents, away from the active edge
  always @(negedge clk)
    if (reset === 1'b0) chk("reset_hold", {out_en, out}, '0);
    else if (out_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_valid: got out=%h with no expected result, expected out_en=0", out);
      end else chk("data", {1'b0, out}, {1'b0, exp_q.pop_front()});
    end else chk("idle_zero", {out_en, out}, '0);

  initial begin
    logic [7:0] sweep[6];
    sweep = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'h81, 8'hFF};
    reset = 1'b0;
    en = 1'b1;
    in = {L{8'h55}};
    #1 chk("reset_async", {out_en, out}, '0);
    #11 reset = 1'b1;
    @(posedge clk);
    #1 chk("first_after_reset", {out_en, out}, {1'b1, {L{8'h55}}});
    foreach (sweep[i]) drive(1'b1, {L{sweep[i]}});
    drive(1'b1, 32'h8010F07F);
    @(posedge clk);
    #1 chk("multi_lane", {out_en, out}, {1'b1, 32'h0010007F});
    for (int i = 0; i < 60; i++) drive(i < 10 || (i >= 20 && i < 30), $urandom);
    drive(1'b1, {L{8'h7F}});
    @(posedge clk);
    #1 chk("pre_reset", {out_en, out}, {1'b1, {L{8'h7F}}});
    #2 reset = 1'b0;
    #1 chk("mid_reset", {out_en, out}, '0);
    @(negedge clk);
    #2 reset = 1'b1;
    drive(1'b1, 32'h01F27F80);
    drive(1'b1, 32'h7E7F8081);
    @(posedge clk);
    #1 chk("resume", {out_en, out}, {1'b1, 32'h7E7F0000});
    drive(1'b0, 'x);
    drive(1'b0, 'x);
    @(posedge clk);
    #1 chk("x_tolerance", {out_en, out}, '0);
    for (int i = 0; i < 200; i++) drive($urandom_range(0, 3) != 0, $urandom);
    drive(1'b0, '0);
    repeat (3) @(negedge clk);
    chk("drain", {1'b0, 32'(exp_q.size())}, '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
